// File: rtl/gate_truth_checker.sv
// Sweeps the four {a,b} vectors into the basic gates, holds each for a settle window,
// then checks and/or/xor/not outputs against the truth table and reports the result.
module gate_truth_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic             and_i,
   input  logic             or_i,
   input  logic             xor_i,
   input  logic             not_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec,
   output logic [3:0]       fail_gate
);

   // state  | meaning
   // S_IDLE | waiting for start, last sweep's result held
   // S_RUN  | driving vec_q, settling then comparing
   // S_DONE | one-cycle done pulse, pass valid
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);
   localparam int SUM_W = ERR_W + 3;
   localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'((1 << ERR_W) - 1);

   state_t           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [3:0]       fvec_q, fvec_d;
   logic [3:0]       fgate_q, fgate_d;
   logic             pass_q, pass_d;

   logic [3:0]       exp_bits;
   logic [3:0]       act_bits;
   logic [3:0]       mis;
   logic [2:0]       mis_cnt;
   logic [SUM_W-1:0] err_sum;
   logic             cmp_edge;

   assign exp_bits = {~vec_q[1], vec_q[1] ^ vec_q[0], vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
   assign act_bits = {not_i, xor_i, or_i, and_i};

   // Case inequality so an X/Z on a gate output counts as a mismatch.
   always_comb begin
      mis = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         mis[i] = (act_bits[i] !== exp_bits[i]);
      end
   end

   assign mis_cnt  = {2'b00, mis[0]} + {2'b00, mis[1]} + {2'b00, mis[2]} + {2'b00, mis[3]};
   assign err_sum  = {3'b000, err_q} + SUM_W'(mis_cnt);
   assign cmp_edge = (state_q == S_RUN) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fvec_q  <= '0;
         fgate_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fgate_q <= fgate_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cmp_edge && (vec_q == 2'd3)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fgate_d = fgate_q;
      pass_d  = pass_q;
      if ((state_q == S_IDLE) && start) begin
         vec_d   = '0;
         cnt_d   = '0;
         err_d   = '0;
         fvec_d  = '0;
         fgate_d = '0;
         pass_d  = 1'b0;
      end else if (state_q == S_RUN) begin
         if (!cmp_edge) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            err_d   = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
            fvec_d  = (|mis) ? (fvec_q | (4'b0001 << vec_q)) : fvec_q;
            fgate_d = fgate_q | mis;
            cnt_d   = '0;
            vec_d   = vec_q + 2'd1;
            // Final vector: pass must already be valid in the DONE cycle.
            if (vec_q == 2'd3) pass_d = ~|fvec_d;
         end
      end
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
      a_o  = (state_q == S_RUN) & vec_q[1];
      b_o  = (state_q == S_RUN) & vec_q[0];
   end

   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fvec_q;
   assign fail_gate = fgate_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: two checker instances (settle 2 / width 5 and settle 0 / width 3)
// drive a shared faulty-gate table; expected sweep results are queued at start accept.
module tb_gate_truth_checker;

   typedef struct {
      int         acc;
      logic [4:0] err;
      logic [3:0] fv;
      logic [3:0] fg;
      logic       ps;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q [2][$];
   logic [3:0] tbl [4];

   logic       a0, b0, busy0, done0, pass0;
   logic [4:0] err0;
   logic [3:0] fv0, fg0;
   logic       a1, b1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [3:0] fv1, fg1;
   logic [3:0] g0, g1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign g0 = tbl[{a0, b0}];
   assign g1 = tbl[{a1, b1}];

   gate_truth_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a_o(a0), .b_o(b0),
      .and_i(g0[0]), .or_i(g0[1]), .xor_i(g0[2]), .not_i(g0[3]),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_vec(fv0), .fail_gate(fg0));

   gate_truth_checker #(.SETTLE_CYCLES(0), .ERR_W(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a_o(a1), .b_o(b1),
      .and_i(g1[0]), .or_i(g1[1]), .xor_i(g1[2]), .not_i(g1[3]),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_vec(fv1), .fail_gate(fg1));

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [3:0] truth(input int v);
      logic a, b;
      a = v[1];
      b = v[0];
      return {~a, a ^ b, a | b, a & b};
   endfunction

   // Reference: count wrong bits over the whole table, then clamp to the counter width.
   function automatic exp_t model(input int w, input int acc);
      exp_t e;
      int   tot;
      logic [3:0] m;
      tot  = 0;
      e.fv = 4'b0;
      e.fg = 4'b0;
      for (int v = 0; v < 4; v++) begin
         m = tbl[v] ^ truth(v);
         tot += $countones(m);
         e.fv[v] = (m != 0);
         e.fg = e.fg | m;
      end
      e.ps  = (tot == 0);
      e.err = 5'((tot > (1 << w) - 1) ? (1 << w) - 1 : tot);
      e.acc = acc;
      return e;
   endfunction

   task automatic mon(input int d, input int s, input logic bsy, input logic dn,
                      input logic a, input logic b, input logic ps,
                      input logic [4:0] err, input logic [3:0] fv, input logic [3:0] fg);
      exp_t e;
      int   k, len;
      len = 4 * (s + 1);
      if (q[d].size() == 0) begin
         if (dn) check($sformatf("dut%0d unexpected_done", d), 1, 0);
      end else begin
         e = q[d][0];
         k = cyc - e.acc;
         check($sformatf("dut%0d busy k=%0d", d, k), int'(bsy), int'(k < len));
         if (k < len) check($sformatf("dut%0d vec k=%0d", d, k), int'({a, b}), k / (s + 1));
         check($sformatf("dut%0d done k=%0d", d, k), int'(dn), int'(k == len));
         if (dn) begin
            void'(q[d].pop_front());
            check($sformatf("dut%0d err_count", d), int'(err), int'(e.err));
            check($sformatf("dut%0d fail_vec", d), int'(fv), int'(e.fv));
            check($sformatf("dut%0d fail_gate", d), int'(fg), int'(e.fg));
            check($sformatf("dut%0d pass", d), int'(ps), int'(e.ps));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, 2, busy0, done0, a0, b0, pass0, err0, fv0, fg0);
         mon(1, 0, busy1, done1, a1, b1, pass1, {2'b00, err1}, fv1, fg1);
      end
   end

   task automatic check_zero(input string tag);
      check({tag, " dut0 outs"}, int'({a0, b0, busy0, done0, pass0, err0, fv0, fg0}), 0);
      check({tag, " dut1 outs"}, int'({a1, b1, busy1, done1, pass1, err1, fv1, fg1}), 0);
   endtask

   task automatic set_tbl(input int mode);
      for (int v = 0; v < 4; v++) begin
         case (mode)
            1:       tbl[v] = truth(v) & 4'b1110;
            2:       tbl[v] = {v[1] ? 1'b1 : 1'b0, truth(v)[2:0]};
            3:       tbl[v] = 4'b1111;
            4:       tbl[v] = truth(v) ^ (($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0);
            default: tbl[v] = truth(v);
         endcase
      end
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 200 && (q[0].size() != 0 || q[1].size() != 0); i++) @(posedge clk);
      if (q[0].size() != 0 || q[1].size() != 0) begin
         check("sweep_timeout", 1, 0);
         q[0].delete();
         q[1].delete();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic issue_start(input bit repulse, input bit wait_end);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      q[0].push_back(model(5, cyc));
      q[1].push_back(model(3, cyc));
      if (repulse) begin
         repeat (2) @(negedge clk);
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      if (wait_end) wait_idle();
   endtask

   initial begin
      int i;
      set_tbl(0);
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      set_tbl(0); issue_start(1'b0, 1'b1);
      set_tbl(1); issue_start(1'b0, 1'b1);
      set_tbl(2); issue_start(1'b0, 1'b1);
      set_tbl(3); issue_start(1'b0, 1'b1);
      set_tbl(1); issue_start(1'b1, 1'b1);
      set_tbl(0); issue_start(1'b0, 1'b1);

      // Abort a sweep with reset while the slow instance drives vector 2.
      set_tbl(3); issue_start(1'b0, 1'b0);
      for (i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (busy0 && a0 && !b0) break;
      end
      if (i == 50) check("reach_vec2", 0, 1);
      rst_n = 1'b0;
      q[0].delete();
      q[1].delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_zero("midreset");
      repeat (20) @(posedge clk);
      set_tbl(0); issue_start(1'b0, 1'b1);

      for (int n = 0; n < 20; n++) begin
         set_tbl(4);
         issue_start(1'b0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
